// File: rtl/sweep_pkg.sv
// sweep_pkg: shared definitions for the triangle sweep controller.
//   - sweep_state_e   : controller state encoding (IDLE/UP/HOLD/DOWN/DONE)
//   - MODE_ONESHOT / MODE_CONT : values of the mode input
//   - SWEEP_N_DEFAULT : default counter/bound width
package sweep_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_UP   = 3'd1,
      S_HOLD = 3'd2,
      S_DOWN = 3'd3,
      S_DONE = 3'd4
   } sweep_state_e;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_CONT    = 1'b1;

   localparam int SWEEP_N_DEFAULT = 8;

endpackage : sweep_pkg

// File: rtl/sweep_counter.sv
// sweep_counter: N-bit loadable up/down counter driven by the sweep FSM.
// Ports:
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset (count -> 0)
//   en_i       : step the counter by one this cycle
//   up_i       : step direction, 1 = +1, 0 = -1
//   load_i     : load load_val_i (takes priority over en_i)
//   load_val_i : value loaded when load_i is high
//   count_o    : registered count value
module sweep_counter #(
   parameter int N = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         up_i,
   input  logic         load_i,
   input  logic [N-1:0] load_val_i,
   output logic [N-1:0] count_o
);

   logic [N-1:0] count_q;
   logic [N-1:0] count_d;

   // Next count: load beats step, otherwise hold
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         if (up_i) begin
            count_d = count_q + N'(1);
         end else begin
            count_d = count_q - N'(1);
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : sweep_counter

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: sequences an N-bit counter through triangle sweeps lo..hi..lo,
// one-shot or continuous, with pause, graceful stop and immediate abort.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start, mode       : sweep request (IDLE only), 0 = one-shot / 1 = continuous
//   lo, hi            : bounds, latched when a start is accepted (needs lo < hi)
//   pause, stop, abort: freeze, end continuous sweep at next lo, return to IDLE now
//   count, dir        : current sweep value and direction (1 = up)
//   busy, done        : not IDLE; one-cycle completion pulse
//   cfg_err           : one-cycle pulse when a start is rejected (lo >= hi)
// Build option: define SWEEP_DWELL_EN to hold the hi bound for DWELL extra
// cycles (HOLD state). DWELL must be >= 1 when the option is enabled.
module sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int N     = SWEEP_N_DEFAULT,
   parameter int DWELL = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         mode,
   input  logic [N-1:0] lo,
   input  logic [N-1:0] hi,
   input  logic         pause,
   input  logic         stop,
   input  logic         abort,
   output logic [N-1:0] count,
   output logic         dir,
   output logic         busy,
   output logic         done,
   output logic         cfg_err
);

   sweep_state_e state_q;
   sweep_state_e state_d;
   logic [N-1:0] lo_q;
   logic [N-1:0] hi_q;
   logic         mode_q;
   logic         stop_q;
   logic         stop_d;
   logic         dir_q;
   logic         dir_d;
   logic         busy_q;
   logic         done_q;
   logic         cfg_err_q;

   logic         start_ok;
   logic         start_bad;
   logic         cnt_en;
   logic         cnt_up;
   logic         cnt_load;

`ifdef SWEEP_DWELL_EN
   localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dwell_d;
`else
   // DWELL has no role without the dwell option
   if (DWELL < 0) begin : g_dwell_unused
   end
`endif

   // Start qualification; abort outranks start in the same cycle
   always_comb begin
      start_ok  = 1'b0;
      start_bad = 1'b0;
      if ((state_q == S_IDLE) && start && !abort) begin
         if (lo < hi) begin
            start_ok = 1'b1;
         end else begin
            start_bad = 1'b1;
         end
      end else begin
         start_ok  = 1'b0;
         start_bad = 1'b0;
      end
   end

   // Next-state and counter control
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      cnt_en   = 1'b0;
      cnt_up   = 1'b1;
      cnt_load = 1'b0;
`ifdef SWEEP_DWELL_EN
      dwell_d  = dwell_q;
`endif
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  state_d  = S_UP;
                  cnt_load = 1'b1;
                  dir_d    = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_UP: begin
               if (pause) begin
                  state_d = S_UP;
               end else if (count != hi_q) begin
                  cnt_en = 1'b1;
                  cnt_up = 1'b1;
               end else begin
                  dir_d = 1'b0;
`ifdef SWEEP_DWELL_EN
                  // hi stays on the output while HOLD runs
                  state_d = S_HOLD;
                  dwell_d = '0;
`else
                  // stepping down from hi lands on hi-1
                  state_d = S_DOWN;
                  cnt_en  = 1'b1;
                  cnt_up  = 1'b0;
`endif
               end
            end
`ifdef SWEEP_DWELL_EN
            S_HOLD: begin
               if (pause) begin
                  state_d = S_HOLD;
               end else if (dwell_q == DWELL_W'(DWELL - 1)) begin
                  state_d = S_DOWN;
                  cnt_en  = 1'b1;
                  cnt_up  = 1'b0;
               end else begin
                  dwell_d = dwell_q + DWELL_W'(1);
               end
            end
`endif
            S_DOWN: begin
               if (pause) begin
                  state_d = S_DOWN;
               end else if (count != lo_q) begin
                  cnt_en = 1'b1;
                  cnt_up = 1'b0;
               end else if ((mode_q == MODE_CONT) && !stop_q) begin
                  // stepping up from lo lands on lo+1
                  state_d = S_UP;
                  cnt_en  = 1'b1;
                  cnt_up  = 1'b1;
                  dir_d   = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Sticky stop request, dropped whenever the FSM heads to IDLE
   always_comb begin
      stop_d = stop_q;
      if (state_d == S_IDLE) begin
         stop_d = 1'b0;
      end else if (stop && (state_q != S_IDLE)) begin
         stop_d = 1'b1;
      end else begin
         stop_d = stop_q;
      end
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         lo_q      <= '0;
         hi_q      <= '0;
         mode_q    <= MODE_ONESHOT;
         stop_q    <= 1'b0;
         dir_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         stop_q    <= stop_d;
         dir_q     <= dir_d;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_d == S_DONE);
         cfg_err_q <= start_bad;
         if (start_ok) begin
            lo_q   <= lo;
            hi_q   <= hi;
            mode_q <= mode;
         end
      end
   end

`ifdef SWEEP_DWELL_EN
   // Dwell counter for the HOLD state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell_q <= '0;
      end else begin
         dwell_q <= dwell_d;
      end
   end
`endif

   sweep_counter #(
      .N (N)
   ) u_counter (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .en_i       (cnt_en),
      .up_i       (cnt_up),
      .load_i     (cnt_load),
      .load_val_i (lo),
      .count_o    (count)
   );

   assign dir     = dir_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign cfg_err = cfg_err_q;

endmodule : sweep_ctrl
